shared_memory_responder: RTL and testbench

//  Responder end of the shared-memory interface driven by memory_controller.

---
 rtl/shared_memory_responder.sv | 124 ++++++++++++
 tb/tb_shared_memory_responder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/shared_memory_responder.sv
// Responder end of the shared-memory interface: vector bank (port A) and ternary weight bank (port B).
// Each new input tuple launches one access that stalls on mem_busy for ACCESS_LAT cycles, then commits.
module shared_memory_responder #(
    parameter int VECTOR_WIDTH = 32,
    parameter int VEC_DEPTH    = 64,
    parameter int MAT_DEPTH    = 256,
    parameter int ACCESS_LAT   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [5:0]              mem_addr_a,
    input  logic                    mem_we_a,
    input  logic [VECTOR_WIDTH-1:0] mem_wdata_a,
    output logic [VECTOR_WIDTH-1:0] mem_rdata_a,
    input  logic [7:0]              mem_addr_b,
    input  logic                    mem_we_b,
    input  logic [1:0]              mem_wdata_b,
    output logic [1:0]              mem_rdata_b,
    output logic                    mem_busy,
    output logic [1:0]              mem_error
);

    localparam int          LW      = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;
    localparam int          VAW     = (VEC_DEPTH > 1) ? $clog2(VEC_DEPTH) : 1;
    localparam int          MAW     = (MAT_DEPTH > 1) ? $clog2(MAT_DEPTH) : 1;
    localparam bit          SINGLE  = (ACCESS_LAT == 1);
    localparam logic [6:0]  VEC_LIM = 7'(VEC_DEPTH);
    localparam logic [8:0]  MAT_LIM = 9'(MAT_DEPTH);

    typedef struct packed {
        logic [5:0]              addr_a;
        logic                    we_a;
        logic [VECTOR_WIDTH-1:0] wdata_a;
        logic [7:0]              addr_b;
        logic                    we_b;
        logic [1:0]              wdata_b;
    } tuple_t;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state;
    logic [LW-1:0]           lat_cnt;
    logic                    tuple_valid;
    tuple_t                  cap_t;
    tuple_t                  last_t;

    logic [VECTOR_WIDTH-1:0] vec_mem [VEC_DEPTH];
    logic [1:0]              wgt_mem [MAT_DEPTH];

    tuple_t                  cur_t;
    tuple_t                  done_t;
    logic                    launch;
    logic                    commit;
    logic                    a_bad;
    logic                    a_wr;
    logic                    b_bad;
    logic                    b_ill;
    logic                    b_wr;
    logic [VAW-1:0]          a_idx;
    logic [MAW-1:0]          b_idx;

    always_comb begin
        cur_t  = '{addr_a: mem_addr_a, we_a: mem_we_a, wdata_a: mem_wdata_a,
                   addr_b: mem_addr_b, we_b: mem_we_b, wdata_b: mem_wdata_b};
        launch = (state == IDLE) && (!tuple_valid || (cur_t != last_t));
        mem_busy = (state == BUSY) || launch;
        // Single-cycle latency commits straight from the live inputs on the launch edge.
        done_t = (state == IDLE) ? cur_t : cap_t;
        commit = rst_n && ((SINGLE && launch) || ((state == BUSY) && (lat_cnt == LW'(1))));
        a_bad  = {1'b0, done_t.addr_a} >= VEC_LIM;
        a_wr   = !a_bad && done_t.we_a;
        b_bad  = {1'b0, done_t.addr_b} >= MAT_LIM;
        b_ill  = !b_bad && done_t.we_b && (done_t.wdata_b == 2'b10);
        b_wr   = !b_bad && done_t.we_b && !b_ill;
        a_idx  = done_t.addr_a[VAW-1:0];
        b_idx  = done_t.addr_b[MAW-1:0];
    end

    always_ff @(posedge clk) begin
        if (commit && a_wr) vec_mem[a_idx] <= done_t.wdata_a;
        if (commit && b_wr) wgt_mem[b_idx] <= done_t.wdata_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            tuple_valid <= 1'b0;
            cap_t       <= '0;
            last_t      <= '0;
            mem_rdata_a <= '0;
            mem_rdata_b <= '0;
            mem_error   <= '0;
        end else begin
            mem_error <= '0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        cap_t       <= cur_t;
                        last_t      <= cur_t;
                        tuple_valid <= 1'b1;
                        lat_cnt     <= LW'(ACCESS_LAT - 1);
                        if (!SINGLE) state <= BUSY;
                    end
                end
                BUSY: begin
                    lat_cnt <= lat_cnt - LW'(1);
                    if (lat_cnt == LW'(1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (commit) begin
                if (a_bad)             mem_error[0] <= 1'b1;
                else if (done_t.we_a)  mem_rdata_a  <= done_t.wdata_a;
                else                   mem_rdata_a  <= vec_mem[a_idx];
                if (b_bad)             mem_error[0] <= 1'b1;
                else if (b_ill)        mem_error[1] <= 1'b1;
                else if (done_t.we_b)  mem_rdata_b  <= done_t.wdata_b;
                else                   mem_rdata_b  <= wgt_mem[b_idx];
            end
        end
    end

endmodule

// File: tb/tb_shared_memory_responder.sv
// Bench for shared_memory_responder: directed accesses push expectations into a queue,
// a monitor pops and compares at the first busy-low cycle after each access.
module tb_shared_memory_responder;

    logic        clk;
    logic        rst_n;
    logic [5:0]  mem_addr_a;
    logic        mem_we_a;
    logic [31:0] mem_wdata_a;
    logic [31:0] mem_rdata_a;
    logic [7:0]  mem_addr_b;
    logic        mem_we_b;
    logic [1:0]  mem_wdata_b;
    logic [1:0]  mem_rdata_b;
    logic        mem_busy;
    logic [1:0]  mem_error;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        bit          ca;
        logic [1:0]  b;
        bit          cb;
        logic [1:0]  e;
    } exp_t;

    exp_t q[$];

    shared_memory_responder #(
        .VECTOR_WIDTH(32),
        .VEC_DEPTH(32),
        .MAT_DEPTH(256),
        .ACCESS_LAT(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mem_addr_a(mem_addr_a),
        .mem_we_a(mem_we_a),
        .mem_wdata_a(mem_wdata_a),
        .mem_rdata_a(mem_rdata_a),
        .mem_addr_b(mem_addr_b),
        .mem_we_b(mem_we_b),
        .mem_wdata_b(mem_wdata_b),
        .mem_rdata_b(mem_rdata_b),
        .mem_busy(mem_busy),
        .mem_error(mem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: count busy-high cycles, compare when busy drops
    int hi_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hi_cnt = 0;
        end else if (mem_busy) begin
            hi_cnt++;
        end else if (hi_cnt != 0) begin
            chk("busy_cycles", hi_cnt, 2);
            hi_cnt = 0;
            if (q.size() == 0) begin
                chk("unexpected_access", 1, 0);
            end else begin
                e = q.pop_front();
                if (e.ca) chk("rdata_a", mem_rdata_a, e.a);
                if (e.cb) chk("rdata_b", {30'b0, mem_rdata_b}, {30'b0, e.b});
                chk("mem_error", {30'b0, mem_error}, {30'b0, e.e});
            end
        end
    end

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!mem_busy) done = 1;
        end
        if (!done) chk("busy_timeout", 1, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [5:0] aa, input logic wa, input logic [31:0] da,
                          input logic [7:0] ab, input logic wb, input logic [1:0] db);
        mem_addr_a  = aa;
        mem_we_a    = wa;
        mem_wdata_a = da;
        mem_addr_b  = ab;
        mem_we_b    = wb;
        mem_wdata_b = db;
    endtask

    task automatic access(input logic [5:0] aa, input logic wa, input logic [31:0] da,
                          input logic [7:0] ab, input logic wb, input logic [1:0] db,
                          input logic [31:0] ea, input bit ca,
                          input logic [1:0] eb, input bit cb, input logic [1:0] ee);
        q.push_back('{a: ea, ca: ca, b: eb, cb: cb, e: ee});
        set_in(aa, wa, da, ab, wb, db);
        wait_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        set_in(6'd5, 1'b0, 32'h0, 8'h00, 1'b0, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdata_a", mem_rdata_a, 32'h0);
        chk("reset_rdata_b", {30'b0, mem_rdata_b}, 32'h0);
        chk("reset_error", {30'b0, mem_error}, 32'h0);

        // First access after reset: read of addr 5, contents unknown
        q.push_back('{a: 32'h0, ca: 0, b: 2'b00, cb: 0, e: 2'b00});
        rst_n = 1'b1;
        wait_idle();

        // Held write: exactly one launch
        access(6'd3, 1'b1, 32'hDEADBEEF, 8'h10, 1'b1, 2'b01, 32'hDEADBEEF, 1, 2'b01, 1, 2'b00);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("held_no_busy", {31'b0, mem_busy}, 32'h0);
        end
        @(posedge clk);
        #1;
        access(6'd3, 1'b0, 32'hDEADBEEF, 8'h10, 1'b0, 2'b01, 32'hDEADBEEF, 1, 2'b01, 1, 2'b00);

        // Illegal weight code dropped
        access(6'd3, 1'b0, 32'h0, 8'h10, 1'b1, 2'b10, 32'hDEADBEEF, 1, 2'b01, 1, 2'b10);
        access(6'd3, 1'b0, 32'h1, 8'h10, 1'b0, 2'b10, 32'hDEADBEEF, 1, 2'b01, 1, 2'b00);

        // Out-of-range vector read / write
        access(6'd40, 1'b0, 32'h1, 8'h10, 1'b0, 2'b10, 32'hDEADBEEF, 1, 2'b01, 1, 2'b01);

        // Simultaneous writes on both ports, then read-back
        access(6'd7, 1'b1, 32'h12345678, 8'd200, 1'b1, 2'b11, 32'h12345678, 1, 2'b11, 1, 2'b00);
        access(6'd7, 1'b0, 32'h12345678, 8'd200, 1'b0, 2'b11, 32'h12345678, 1, 2'b11, 1, 2'b00);

        access(6'd9, 1'b1, 32'h11111111, 8'd200, 1'b0, 2'b11, 32'h11111111, 1, 2'b11, 1, 2'b00);
        access(6'd40, 1'b1, 32'hCAFEF00D, 8'd200, 1'b0, 2'b11, 32'h11111111, 1, 2'b11, 1, 2'b01);
        access(6'd9, 1'b0, 32'h0, 8'd255, 1'b1, 2'b00, 32'h11111111, 1, 2'b00, 1, 2'b00);
        access(6'd9, 1'b0, 32'h0, 8'd200, 1'b0, 2'b00, 32'h11111111, 1, 2'b11, 1, 2'b00);

        // Reset during BUSY of a write to addr 9
        set_in(6'd9, 1'b1, 32'h99999999, 8'd200, 1'b0, 2'b00);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        set_in(6'd9, 1'b0, 32'h0, 8'd200, 1'b0, 2'b00);
        @(posedge clk);
        #1;
        chk("midreset_rdata_a", mem_rdata_a, 32'h0);
        chk("midreset_error", {30'b0, mem_error}, 32'h0);
        q.push_back('{a: 32'h11111111, ca: 1, b: 2'b11, cb: 1, e: 2'b00});
        rst_n = 1'b1;
        @(negedge clk);
        chk("busy_after_reset", {31'b0, mem_busy}, 32'h1);
        wait_idle();

        repeat (4) @(posedge clk);
        #1;
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
